// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: raster-order BRAM read master with a valid/ready pixel stream.
// Optional macro FB_SCANOUT_CONTINUOUS_EN: free-running back-to-back frames.
module fb_scanout_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int H_RES      = 320,
  parameter int V_RES      = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_eol,
  output logic                  m_last,
  output logic                  frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  eol;
    logic                  last;
  } beat_t;

  state_t state_q;
  state_t state_d;

  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [ADDR_WIDTH-1:0] raddr_q;

  logic inflight_q;
  logic if_eol_q;
  logic if_last_q;

  beat_t      head_q;
  beat_t      tail_q;
  beat_t      nb;
  logic [1:0] occ_q;

  logic       frame_done_q;
  logic       push;
  logic       pop;
  logic       x_end;
  logic       y_end;
  logic       last_issue;
  logic [2:0] occ_sum;
  logic       room;
  logic       issue;
  logic       clr_cnt;

  assign push       = inflight_q;
  assign m_valid    = (occ_q != 2'd0);
  assign pop        = m_valid & m_ready;
  assign x_end      = (x_q == X_MAX);
  assign y_end      = (y_q == Y_MAX);
  assign last_issue = x_end & y_end;

  // Occupancy after this edge if one more read were launched.
  assign occ_sum = {1'b0, occ_q}
                 + {2'b00, inflight_q}
                 - {2'b00, pop};
  assign room    = (occ_sum < 3'd2);

  assign nb = '{data: rdata, eol: if_eol_q, last: if_last_q};

  // Frame sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, issue decision and counter clear.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    clr_cnt = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_cnt = 1'b1;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        issue = room;
`ifndef FB_SCANOUT_CONTINUOUS_EN
        if (room && last_issue) begin
          state_d = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (pop && head_q.last) begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr_cnt = 1'b1;
      end
    endcase
  end

  // Raster position and linear read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      raddr_q <= '0;
    end else if (clr_cnt) begin
      x_q     <= '0;
      y_q     <= '0;
      raddr_q <= '0;
    end else if (issue) begin
      if (last_issue) begin
`ifdef FB_SCANOUT_CONTINUOUS_EN
        x_q     <= '0;
        y_q     <= '0;
        raddr_q <= '0;
`endif
      end else if (x_end) begin
        x_q     <= '0;
        y_q     <= y_q + YW'(1);
        raddr_q <= raddr_q + ADDR_WIDTH'(1);
      end else begin
        x_q     <= x_q + XW'(1);
        raddr_q <= raddr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Tags travel alongside the one outstanding BRAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      if_eol_q   <= 1'b0;
      if_last_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        if_eol_q  <= x_end;
        if_last_q <= last_issue;
      end
    end
  end

  // Two-entry skid buffer; head always drives the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= nb;
          end else begin
            tail_q <= nb;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= nb;
          end else begin
            head_q <= nb;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pulse one cycle after the frame's final pixel is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop & head_q.last;
    end
  end

  assign busy       = (state_q != IDLE);
  assign raddr      = raddr_q;
  assign m_data     = head_q.data;
  assign m_eol      = m_valid & head_q.eol;
  assign m_last     = m_valid & head_q.last;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb_fb_scanout_reader: scoreboard bench for fb_scanout_reader, 4x2 frame.
// Build with FB_SCANOUT_CONTINUOUS_EN to exercise the free-running mode.
module tb_fb_scanout_reader;

  localparam int DW   = 8;
  localparam int AW   = 17;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int NPIX = HR * VR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_eol;
  logic          m_last;
  logic          frame_done;

  fb_scanout_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .H_RES     (HR),
    .V_RES     (VR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .raddr     (raddr),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_eol     (m_eol),
    .m_last    (m_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:NPIX-1];
  initial for (int i = 0; i < NPIX; i++) ram[i] = DW'(i + 16);
  always @(posedge clk) rdata <= ram[raddr[2:0]];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          eol;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   beats = 0;
  int   fds = 0;
  bit   fd_pend = 1'b0;
  bit   stalled = 1'b0;
  int   b0;
  int   f0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_t e;
      e.d    = DW'(i + 16);
      e.eol  = ((i % HR) == HR - 1);
      e.last = (i == NPIX - 1);
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (q.size() != 0 || busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    repeat (2) tick();
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beats < target && n < budget) begin
      tick();
      n++;
    end
    if (beats < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got %0d want %0d", beats, target);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      fd_pend = 1'b0;
      stalled = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_pend));
      if (frame_done) fds++;
      fd_pend = 1'b0;
      if (stalled) chk("valid_hold", 32'(m_valid), 32'd1);
      if (m_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got 0x%0h want none", m_data);
        end else begin
          chk("data", 32'(m_data), 32'(q[0].d));
          chk("eol", 32'(m_eol), 32'(q[0].eol));
          chk("last", 32'(m_last), 32'(q[0].last));
          if (m_ready) begin
            fd_pend = q[0].last;
            void'(q.pop_front());
            beats++;
          end
        end
      end
      stalled = m_valid && !m_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_raddr"}, 32'(raddr), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
    chk({tag, "_eol"}, 32'(m_eol), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    bit [3:0] pat;
    pat = 4'b1001;
    rst_n   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    #2 rst_n = 1'b1;
    tick();

`ifndef FB_SCANOUT_CONTINUOUS_EN
    // Free-run frame.
    b0 = beats;
    f0 = fds;
    push_frame();
    pulse_start();
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_lat0", 32'(m_valid), 32'd0);
    tick();
    chk("s1_lat1", 32'(m_valid), 32'd0);
    tick();
    chk("s1_lat2", 32'(m_valid), 32'd1);
    for (int i = 1; i < NPIX; i++) begin
      tick();
      chk("s1_no_gap", 32'(m_valid), 32'd1);
    end
    tick();
    chk("s1_fd", 32'(frame_done), 32'd1);
    chk("s1_idle", 32'(busy), 32'd0);
    wait_empty(50);
    chk("s1_beats", 32'(beats - b0), 32'd8);
    chk("s1_fds", 32'(fds - f0), 32'd1);

    // Backpressure: full stall, then 1,0,0,1 with a long hold.
    b0 = beats;
    f0 = fds;
    m_ready = 1'b0;
    push_frame();
    pulse_start();
    repeat (12) tick();
    chk("s2_raddr_hold", 32'(raddr), 32'd2);
    chk("s2_valid", 32'(m_valid), 32'd1);
    chk("s2_head", 32'(m_data), 32'h10);
    for (int i = 0; i < 40; i++) begin
      m_ready = pat[i % 4];
      if (i >= 8 && i < 18) m_ready = 1'b0;
      tick();
    end
    m_ready = 1'b1;
    wait_empty(50);
    chk("s2_beats", 32'(beats - b0), 32'd8);
    chk("s2_fds", 32'(fds - f0), 32'd1);

    // start while busy is ignored.
    b0 = beats;
    f0 = fds;
    push_frame();
    pulse_start();
    wait_beats(b0 + 3, 50);
    pulse_start();
    wait_empty(50);
    chk("s3_beats", 32'(beats - b0), 32'd8);
    chk("s3_fds", 32'(fds - f0), 32'd1);

    // Asynchronous reset mid-frame, then a clean frame.
    b0 = beats;
    push_frame();
    pulse_start();
    wait_beats(b0 + 3, 50);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("s4");
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    b0 = beats;
    f0 = fds;
    push_frame();
    pulse_start();
    wait_empty(50);
    chk("s4_beats", 32'(beats - b0), 32'd8);
    chk("s4_fds", 32'(fds - f0), 32'd1);

    // Back-to-back frames, restart on the frame_done cycle.
    b0 = beats;
    f0 = fds;
    push_frame();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!frame_done && n < 50) begin
        tick();
        n++;
      end
      chk("s5_fd_seen", 32'(frame_done), 32'd1);
    end
    start = 1'b1;
    push_frame();
    tick();
    tick();
    start = 1'b0;
    wait_empty(50);
    chk("s5_beats", 32'(beats - b0), 32'd16);
    chk("s5_fds", 32'(fds - f0), 32'd2);
`else
    // Continuous frames with m_ready held high.
    b0 = beats;
    f0 = fds;
    repeat (4) push_frame();
    pulse_start();
    tick();
    tick();
    for (int i = 0; i < 24; i++) begin
      chk("s6_no_gap", 32'(m_valid), 32'd1);
      chk("s6_busy", 32'(busy), 32'd1);
      tick();
    end
    tick();
    chk("s6_beats", 32'(beats - b0), 32'd25);
    chk("s6_fds", 32'(fds - f0), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("s6");
    q.delete();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
Read-side master for the framebuffer/depth BRAM. It walks the whole buffer in raster order on the BRAM read port, whose read latency is 1 cycle. It returns pixels as a valid/ready stream with line and frame markers. It feeds the display controller, or any consumer that drains a full buffer, and tolerates arbitrary backpressure without losing or duplicating pixels.

Parameters:
DATA_WIDTH, 8, pixel/word width; matches BRAM DATA_WIDTH
ADDR_WIDTH, 17, BRAM address width
H_RES, 320, pixels per line
V_RES, 240, lines per frame; H_RES*V_RES must be <= 2**ADDR_WIDTH

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame request; sampled only in IDLE
busy  out  1  high in RUN and DRAIN
raddr  out  ADDR_WIDTH  BRAM read address, driven from a register
rdata  in  DATA_WIDTH  BRAM dout, valid 1 cycle after raddr is presented
m_valid  out  1  stream data valid
m_ready  in  1  consumer ready
m_data  out  DATA_WIDTH  pixel
m_eol  out  1  m_data is the last pixel of a line (x == H_RES-1)
m_last  out  1  m_data is the final pixel of the frame
frame_done  out  1  1-cycle pulse after the final pixel handshakes

Behaviour:
- Reset (async, rst_n=0): state=IDLE. raddr, all counters, buffer contents/occupancy, in-flight flag, m_valid, m_data, m_eol, m_last, busy and frame_done all 0. Reset mid-frame flushes everything; there is no resume.
- States:
  - IDLE: start=1 -> RUN, and the issue counter is set to 0.
  - RUN: one read is issued per cycle while the issue condition holds. Once read H_RES*V_RES-1 is issued -> DRAIN.
  - DRAIN: no new issues. After the handshake of the pixel with m_last=1 -> IDLE, and frame_done pulses in the following cycle.
- start is ignored while busy. start in the same cycle as the return to IDLE is not sampled; it is sampled on the next IDLE cycle.
- Issue: raddr = current issue index, which is linear y*H_RES+x and increments by 1. An issue sets the in-flight flag, so rdata is captured at the next edge. Each in-flight read carries its own eol/last tags through the pipeline.
- Output buffer: 2 entries; the head drives m_*.
- Issue condition: in RUN, and (occupancy + inflight - pop) < 2, where pop = m_valid & m_ready this cycle. This guarantees no overflow and gives 1 pixel/cycle sustained when m_ready is held at 1.
- Latency: start sampled at edge E0; raddr=0 is presented after E0; rdata is captured at E2. m_valid rises after E2 (2 cycles from start).
- Handshake: m_data, m_eol and m_last stay stable while m_valid=1 and m_ready=0. Transfer occurs when both are high. m_valid never drops without a transfer.
- m_ready=0 indefinitely: at most 2 pixels are buffered, issue stalls, and raddr holds.
- Simultaneous push and pop on a full buffer is legal. Occupancy is unchanged and order is preserved.
- Counter arithmetic: x wraps at H_RES-1 to 0 and increments y. The last pixel is at x=H_RES-1, y=V_RES-1. raddr never exceeds H_RES*V_RES-1.
- After DRAIN -> IDLE, raddr returns to 0.

Optional Feature:
Macro FB_SCANOUT_CONTINUOUS_EN.
- Defined: after the final issue, the issue counter wraps to 0 and RUN continues directly; DRAIN/IDLE are not entered after the first start. frame_done still pulses 1 cycle after each m_last handshake. There is no bubble between frames when m_ready=1. busy stays 1 until reset.
- Not defined: single-shot behaviour as described in Behaviour; each frame needs a new start.

Test Plan:
All scenarios use H_RES=4, V_RES=2 and the BRAM preloaded with ram[i]=i+0x10.
1. Free-run: m_ready=1, pulse start -> m_valid rises 2 cycles after the start edge; 8 consecutive beats 0x10..0x17; m_eol on 0x13 and 0x17; m_last on 0x17 only; frame_done 1 cycle later; busy low afterwards.
2. Backpressure: m_ready toggles 1,0,0,1,... plus a 10-cycle hold at 0 -> same 8 values in order with no duplicates; occupancy never exceeds 2; m_data stable while stalled.
3. start while busy: pulse start mid-frame -> ignored; exactly 8 beats and one frame_done.
4. Async reset mid-frame: assert rst_n=0 after beat 3, off-edge -> all outputs 0 immediately. A new start after release yields 0x10..0x17 from the beginning.
5. Back-to-back frames: start asserted on the cycle frame_done pulses, held 1 cycle longer -> second frame starts from the IDLE sample; 16 beats total; two frame_done pulses.
6. FB_SCANOUT_CONTINUOUS_EN: single start, m_ready=1 -> 0x10..0x17,0x10.. with no gap cycles; frame_done every 8 beats.
